i2s_tx_serializer: RTL and testbench

- Output stage directly downstream of the hearing-aid core. It consumes the core's per-sample stereo result (24-bit left/right) through a valid/ready handshake and serialises it onto a standard Philips I2S bus toward the DAC/codec.
- BCLK and LRCLK are generated internally by dividing the system clock.
- A one-entry holding buffer decouples the core's sample timing from frame timing. Underruns are flagged.

---
 rtl/i2s_tx_serializer.sv | 220 ++++++++++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// Stereo sample handshake in, Philips I2S (BCLK/LRCLK/SDATA) out toward the DAC.
// Bit and word clocks are divided from clk; a one-entry hold buffer feeds a per-frame shadow.
module i2s_tx_serializer #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_l,
    input  logic [DATA_W-1:0] in_r,
    output logic              i2s_bclk,
    output logic              i2s_lrclk,
    output logic              i2s_sdata,
    output logic              frame_start,
    output logic              underrun,
    input  logic              clear_status,
    output logic              active
);
    localparam int CNT_W = $clog2(2 * SLOT_W);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(2 * SLOT_W - 1);
    localparam logic [CNT_W-1:0] RIGHT_SLOT = CNT_W'(SLOT_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Serial bit for slot position b; each channel starts one BCLK after its LRCLK edge.
    function automatic logic slot_bit(input logic [CNT_W-1:0] b,
                                      input logic [DATA_W-1:0] l,
                                      input logic [DATA_W-1:0] r);
        int unsigned bi;
        logic [IDX_W-1:0] idx;
        logic res;
        bi  = 32'(b);
        idx = {IDX_W{1'b0}};
        if ((bi >= 32'd1) && (bi <= DATA_W)) begin
            idx = IDX_W'(DATA_W - bi);
            res = l[idx];
        end else if ((bi >= SLOT_W + 1) && (bi <= SLOT_W + DATA_W)) begin
            idx = IDX_W'(SLOT_W + DATA_W - bi);
            res = r[idx];
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

    logic [0:0]        state_r, state_n;
    logic [DIV_W-1:0]  div_cnt_r, div_cnt_n;
    logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_n;
    logic [CNT_W-1:0]  bit_inc_s;
    logic              bclk_r, bclk_n;
    logic              lrclk_r, lrclk_n;
    logic              sdata_r, sdata_n;
    logic              frame_start_r, frame_start_n;
    logic              underrun_r, underrun_n;
    logic              active_r, active_n;
    logic              alive_r;
    logic              hold_full_r, hold_full_n;
    logic [DATA_W-1:0] hold_left_r, hold_left_n;
    logic [DATA_W-1:0] hold_right_r, hold_right_n;
    logic [DATA_W-1:0] shadow_left_r, shadow_left_n;
    logic [DATA_W-1:0] shadow_right_r, shadow_right_n;
    logic              load_now_s;
    logic              accept_s;
    logic              underrun_set_s;

    // The shadow is refilled in the frame_start cycle, well before bit 1 is shifted out.
    assign load_now_s     = enable & frame_start_r;
    assign in_ready       = enable & alive_r & (~hold_full_r | load_now_s);
    assign accept_s       = in_valid & in_ready;
    assign underrun_set_s = load_now_s & ~hold_full_r;
    assign bit_inc_s      = (bit_cnt_r == LAST_BIT) ? {CNT_W{1'b0}} : (bit_cnt_r + CNT_W'(1));

    assign i2s_bclk    = bclk_r;
    assign i2s_lrclk   = lrclk_r;
    assign i2s_sdata   = sdata_r;
    assign frame_start = frame_start_r;
    assign underrun    = underrun_r;
    assign active      = active_r;

    // Next state of the frame sequencer, bit-clock divider and serial outputs
    always_comb begin
        state_n       = state_r;
        div_cnt_n     = div_cnt_r;
        bit_cnt_n     = bit_cnt_r;
        bclk_n        = bclk_r;
        lrclk_n       = lrclk_r;
        sdata_n       = sdata_r;
        frame_start_n = 1'b0;
        if (!enable) begin
            state_n   = ST_IDLE;
            div_cnt_n = {DIV_W{1'b0}};
            bit_cnt_n = {CNT_W{1'b0}};
            bclk_n    = 1'b0;
            lrclk_n   = 1'b0;
            sdata_n   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    div_cnt_n = {DIV_W{1'b0}};
                    bit_cnt_n = {CNT_W{1'b0}};
                    bclk_n    = 1'b0;
                    lrclk_n   = 1'b0;
                    sdata_n   = 1'b0;
                    if (hold_full_r) begin
                        state_n       = ST_RUN;
                        frame_start_n = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_n = {DIV_W{1'b0}};
                        bclk_n    = ~bclk_r;
                        // Data and word select only move with the falling bit-clock edge.
                        if (bclk_r) begin
                            bit_cnt_n     = bit_inc_s;
                            lrclk_n       = (bit_inc_s >= RIGHT_SLOT);
                            sdata_n       = slot_bit(bit_inc_s, shadow_left_r, shadow_right_r);
                            frame_start_n = (bit_inc_s == {CNT_W{1'b0}});
                        end else begin
                            bit_cnt_n = bit_cnt_r;
                        end
                    end else begin
                        div_cnt_n = div_cnt_r + DIV_W'(1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
        active_n = (state_n == ST_RUN);
    end

    // Next state of the holding buffer, frame shadow and sticky underrun flag
    always_comb begin
        hold_full_n    = hold_full_r;
        hold_left_n    = hold_left_r;
        hold_right_n   = hold_right_r;
        shadow_left_n  = shadow_left_r;
        shadow_right_n = shadow_right_r;
        underrun_n     = underrun_r;
        if (!enable) begin
            hold_full_n = 1'b0;
        end else if (accept_s) begin
            hold_left_n  = in_l;
            hold_right_n = in_r;
            hold_full_n  = 1'b1;
        end else if (load_now_s) begin
            hold_full_n = 1'b0;
        end else begin
            hold_full_n = hold_full_r;
        end
        if (load_now_s) begin
            if (hold_full_r) begin
                shadow_left_n  = hold_left_r;
                shadow_right_n = hold_right_r;
            end else begin
                shadow_left_n  = {DATA_W{1'b0}};
                shadow_right_n = {DATA_W{1'b0}};
            end
        end else begin
            shadow_left_n  = shadow_left_r;
            shadow_right_n = shadow_right_r;
        end
        if (underrun_set_s) begin
            underrun_n = 1'b1;
        end else if (clear_status) begin
            underrun_n = 1'b0;
        end else begin
            underrun_n = underrun_r;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            div_cnt_r      <= {DIV_W{1'b0}};
            bit_cnt_r      <= {CNT_W{1'b0}};
            bclk_r         <= 1'b0;
            lrclk_r        <= 1'b0;
            sdata_r        <= 1'b0;
            frame_start_r  <= 1'b0;
            underrun_r     <= 1'b0;
            active_r       <= 1'b0;
            alive_r        <= 1'b0;
            hold_full_r    <= 1'b0;
            hold_left_r    <= {DATA_W{1'b0}};
            hold_right_r   <= {DATA_W{1'b0}};
            shadow_left_r  <= {DATA_W{1'b0}};
            shadow_right_r <= {DATA_W{1'b0}};
        end else begin
            state_r        <= state_n;
            div_cnt_r      <= div_cnt_n;
            bit_cnt_r      <= bit_cnt_n;
            bclk_r         <= bclk_n;
            lrclk_r        <= lrclk_n;
            sdata_r        <= sdata_n;
            frame_start_r  <= frame_start_n;
            underrun_r     <= underrun_n;
            active_r       <= active_n;
            alive_r        <= 1'b1;
            hold_full_r    <= hold_full_n;
            hold_left_r    <= hold_left_n;
            hold_right_r   <= hold_right_n;
            shadow_left_r  <= shadow_left_n;
            shadow_right_r <= shadow_right_n;
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Randomised bench for i2s_tx_serializer: a queue model of accepted sample pairs predicts each
// frame's 64-bit serial image, word select, handshake readiness, frame spacing and underrun.
module tb_i2s_tx_serializer;
    localparam int DATA_W     = 24;
    localparam int SLOT_W     = 32;
    localparam int DIV        = 2;
    localparam int BITS       = 2 * SLOT_W;
    localparam int FRAME_CLKS = 4 * SLOT_W * DIV;
    localparam int FRAME_DEF  = 4 * 32 * 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic in_valid = 1'b0;
    logic clear_status = 1'b0;
    logic [DATA_W-1:0] in_l = '0;
    logic [DATA_W-1:0] in_r = '0;
    logic in_ready, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, active;

    logic enable_d = 1'b0;
    logic in_valid_d = 1'b0;
    logic clear_d = 1'b0;
    logic [DATA_W-1:0] in_l_d = '0;
    logic [DATA_W-1:0] in_r_d = '0;
    logic in_ready_d, bclk_d, lrclk_d, sdata_d, frame_start_d, underrun_d, active_d;

    always #5 clk = ~clk;

    i2s_tx_serializer #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .in_l(in_l), .in_r(in_r), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
        .i2s_sdata(i2s_sdata), .frame_start(frame_start), .underrun(underrun),
        .clear_status(clear_status), .active(active)
    );

    i2s_tx_serializer dut_def (
        .clk(clk), .rst(rst), .enable(enable_d), .in_valid(in_valid_d), .in_ready(in_ready_d),
        .in_l(in_l_d), .in_r(in_r_d), .i2s_bclk(bclk_d), .i2s_lrclk(lrclk_d),
        .i2s_sdata(sdata_d), .frame_start(frame_start_d), .underrun(underrun_d),
        .clear_status(clear_d), .active(active_d)
    );

    int checks = 0;
    int errors = 0;
    logic [47:0] q[$];
    logic [63:0] cur_bits = '0;
    bit   cur_valid = 1'b0;
    int   bit_idx = 0;
    bit   gap_track = 1'b0;
    int   gap_cnt = 0;
    logic uf_exp = 1'b0;
    bit   chk_rdy = 1'b0;
    logic prev_bclk = 1'b0;
    bit   acc_last = 1'b0;
    bit   fs_last = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial image of a frame, MSB = bit 0: one idle bit, L, pad, one idle bit, R, pad.
    function automatic logic [63:0] frame_word(input logic [47:0] pr);
        logic [63:0] l64, r64;
        l64 = {40'd0, pr[47:24]};
        r64 = {40'd0, pr[23:0]};
        return (l64 << (BITS - 1 - DATA_W)) | (r64 << (SLOT_W - 1 - DATA_W));
    endfunction

    task automatic model_reset();
        q.delete();
        cur_valid = 1'b0;
        bit_idx   = 0;
        gap_track = 1'b0;
        gap_cnt   = 0;
        uf_exp    = 1'b0;
    endtask

    // Called at a falling clk edge: pre-edge handshake sampling, then outputs after the edge.
    task automatic cyc();
        logic fs, acc, empty, eb;
        #3;
        fs = frame_start;
        acc = in_valid & in_ready;
        fs_last = fs;
        acc_last = acc;
        if (rst) begin
            model_reset();
        end else begin
            empty = (q.size() == 0);
            if (chk_rdy) chk("in_ready", 64'(in_ready), 64'(enable && (empty || fs)));
            if (enable && fs) begin
                if (cur_valid) chk("bits_per_frame", 64'(bit_idx), 64'(BITS));
                if (gap_track) chk("frame_len", 64'(gap_cnt), 64'(FRAME_CLKS));
                cur_bits  = empty ? 64'd0 : frame_word(q.pop_front());
                cur_valid = 1'b1;
                bit_idx   = 0;
                gap_track = 1'b1;
                gap_cnt   = 0;
            end
            if (enable && fs && empty) uf_exp = 1'b1;
            else if (clear_status) uf_exp = 1'b0;
            if (!enable) begin
                q.delete();
                cur_valid = 1'b0;
                gap_track = 1'b0;
            end else if (acc) begin
                q.push_back({in_l, in_r});
            end
            if (gap_track) gap_cnt++;
        end
        @(negedge clk);
        if (!rst) begin
            chk("underrun", 64'(underrun), 64'(uf_exp));
            if (cur_valid && i2s_bclk && !prev_bclk) begin
                if (bit_idx < BITS) begin
                    eb = 1'((cur_bits >> (BITS - 1 - bit_idx)) & 64'd1);
                    chk("lrclk", 64'(i2s_lrclk), 64'(bit_idx >= SLOT_W));
                    chk("sdata", 64'(i2s_sdata), 64'(eb));
                end else begin
                    chk("bit_overrun", 64'(bit_idx), 64'(BITS - 1));
                end
                bit_idx++;
            end
        end
        prev_bclk = i2s_bclk;
    endtask

    task automatic wait_fs(input int budget, input string tag);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (n < budget && !seen) begin
            cyc();
            seen = fs_last;
            n++;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic push_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        int n;
        in_l = l;
        in_r = r;
        in_valid = 1'b1;
        n = 0;
        acc_last = 1'b0;
        while (n < 20 && !acc_last) begin
            cyc();
            n++;
        end
        chk("push_accept", 64'(acc_last), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_bclk"}, 64'(i2s_bclk), 64'd0);
        chk({tag, "_lrclk"}, 64'(i2s_lrclk), 64'd0);
        chk({tag, "_sdata"}, 64'(i2s_sdata), 64'd0);
        chk({tag, "_active"}, 64'(active), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        int n, n_fs;
        model_reset();
        #2 rst = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        // Reset with enable high: everything quiet.
        check_quiet("rst");
        chk("rst_frame_start", 64'(frame_start), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_active", 64'(active), 64'd0);
        repeat (4) begin
            cyc();
            chk("idle_bclk", 64'(i2s_bclk), 64'd0);
        end
        chk_rdy = 1'b1;

        // Single frame, then an underrun frame of zeros.
        push_pair(24'hA5A5A5, 24'h3C3C3C);
        wait_fs(10, "first_frame_start");
        chk("run_active", 64'(active), 64'd1);
        wait_fs(FRAME_CLKS + 8, "second_frame_start");
        chk("underrun_set", 64'(underrun), 64'd1);

        // Clear held across an underrun boundary: the set wins, then clears without an event.
        clear_status = 1'b1;
        wait_fs(FRAME_CLKS + 8, "third_frame_start");
        chk("underrun_set_wins", 64'(underrun), 64'd1);
        cyc();
        chk("underrun_cleared", 64'(underrun), 64'd0);
        clear_status = 1'b0;

        // Continuous supply over eight frames.
        in_l = 24'($urandom);
        in_r = 24'($urandom);
        in_valid = 1'b1;
        n = 0;
        n_fs = 0;
        while (n_fs < 9 && n < 9 * FRAME_CLKS + 64) begin
            cyc();
            n++;
            if (fs_last) n_fs++;
            if (acc_last) begin
                in_l = 24'($urandom);
                in_r = 24'($urandom);
            end
        end
        in_valid = 1'b0;
        chk("b2b_frames", 64'(n_fs), 64'd9);
        chk("b2b_no_underrun", 64'(underrun), 64'd0);

        // Drop enable while bit 10 is on the wire.
        wait_fs(FRAME_CLKS + 8, "disrupt_frame_start");
        n = 0;
        while (bit_idx < 11 && n < 100) begin
            cyc();
            n++;
        end
        chk("reach_bit10", 64'(bit_idx), 64'd11);
        enable = 1'b0;
        cyc();
        check_quiet("disable");
        repeat (3) cyc();
        enable = 1'b1;
        push_pair(24'($urandom), 24'($urandom));
        wait_fs(10, "reenable_frame_start");
        wait_fs(FRAME_CLKS + 8, "reenable_next_frame");

        // Asynchronous reset mid-frame.
        push_pair(24'($urandom), 24'($urandom));
        repeat (40) cyc();
        #2 rst = 1'b1;
        #1;
        check_quiet("async_rst");
        chk("async_rst_underrun", 64'(underrun), 64'd0);
        chk_rdy = 1'b0;
        @(negedge clk);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk_rdy = 1'b1;
        push_pair(24'($urandom), 24'($urandom));
        wait_fs(10, "post_rst_frame_start");
        wait_fs(FRAME_CLKS + 8, "post_rst_next_frame");

        // Frame length at default parameters.
        enable = 1'b0;
        enable_d = 1'b1;
        in_l_d = 24'($urandom);
        in_r_d = 24'($urandom);
        in_valid_d = 1'b1;
        cyc();
        in_valid_d = 1'b0;
        n = 0;
        while (!frame_start_d && n < 10) begin
            cyc();
            n++;
        end
        chk("def_first_frame", 64'(frame_start_d), 64'd1);
        n = 0;
        cyc();
        n++;
        while (!frame_start_d && n < FRAME_DEF + 40) begin
            cyc();
            n++;
        end
        chk("def_frame_len", 64'(n), 64'(FRAME_DEF));
        chk("def_active", 64'(active_d), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
